// File: rtl/vjtag_gpio_pkg.sv
// vjtag_gpio_pkg: shared register map, address field widths and host FSM states
package vjtag_gpio_pkg;
  localparam int CH_W = 5;
  localparam int REG_W = 3;
  localparam int MAX_CH = 8;
  typedef enum logic [REG_W-1:0] {
    REG_OUT, REG_DIR, REG_IN, REG_SET, REG_CLR, REG_RISE_EN, REG_FALL_EN, REG_STATUS
  } reg_e;
  typedef enum logic {S_IDLE, S_RESP} state_e;
endpackage

// File: rtl/vjtag_gpio_bank_channel.sv
// gpio_channel: one channel's registers, two-flop input synchroniser and edge capture
module gpio_channel
  import vjtag_gpio_pkg::*;
#(
  parameter int DW = 16,
  parameter bit RST_OUT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  reg_e          i_reg,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_pad,
  output logic [DW-1:0] o_out,
  output logic [DW-1:0] o_oe,
  output logic [DW-1:0] o_rdata,
  output logic          o_pend
);
  logic [DW-1:0] r_out, r_dir, r_rise, r_fall, r_stat, r_s1, r_s2, r_prev;
  logic          r_arm;
  logic [DW-1:0] w_cap, w_clr;
  assign w_cap = r_arm ? ((r_s2 & ~r_prev & r_rise) | (~r_s2 & r_prev & r_fall)) : '0;
  assign w_clr = (i_we && i_reg == REG_STATUS) ? i_wdata : '0;
  assign o_out = r_out;
  assign o_oe = r_dir;
  assign o_pend = |r_stat;
  // register writes, pad sampling and sticky status where a new capture beats W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= {DW{RST_OUT}};
      r_dir <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_stat <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_prev <= '0;
      r_arm <= 1'b0;
    end else begin
      r_s1 <= i_pad;
      r_s2 <= r_s1;
      r_prev <= r_s2;
      r_arm <= 1'b1;
      r_stat <= (r_stat & ~w_clr) | w_cap;
      if (i_we) begin
        case (i_reg)
          REG_OUT:     r_out <= i_wdata;
          REG_SET:     r_out <= r_out | i_wdata;
          REG_CLR:     r_out <= r_out & ~i_wdata;
          REG_DIR:     r_dir <= i_wdata;
          REG_RISE_EN: r_rise <= i_wdata;
          REG_FALL_EN: r_fall <= i_wdata;
          default:     ;
        endcase
      end
    end
  end
  // readback; write-only SET/CLR read as zero
  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_OUT:     o_rdata = r_out;
      REG_DIR:     o_rdata = r_dir;
      REG_IN:      o_rdata = r_s2;
      REG_RISE_EN: o_rdata = r_rise;
      REG_FALL_EN: o_rdata = r_fall;
      REG_STATUS:  o_rdata = r_stat;
      default:     o_rdata = '0;
    endcase
  end
endmodule

// File: rtl/vjtag_gpio_bank.sv
// vjtag_gpio_bank: host request/response front end over an array of GPIO channels
module vjtag_gpio_bank
  import vjtag_gpio_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DW = 16,
  parameter bit RST_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [7:0]           req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_CH*DW-1:0] gpio_out,
  output logic [NUM_CH*DW-1:0] gpio_oe,
  input  logic [NUM_CH*DW-1:0] gpio_in,
  output logic                 irq
);
  state_e            r_state;
  logic [31:0]       r_rdata;
  logic              r_err, r_irq;
  logic [CH_W-1:0]   w_ch;
  reg_e              w_reg;
  logic              w_acc, w_ok, w_unused;
  logic [DW-1:0]     w_rd;
  logic [DW-1:0]     w_rd_ch [NUM_CH];
  logic [NUM_CH-1:0] w_pend;
  assign w_ch = req_addr[7:REG_W];
  assign w_reg = reg_e'(req_addr[REG_W-1:0]);
  assign w_acc = req_valid && r_state == S_IDLE;
  assign w_ok = w_ch < CH_W'(NUM_CH);
  assign w_unused = ^req_wdata;
  assign req_ready = r_state == S_IDLE;
  assign rsp_valid = r_state == S_RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err = r_err;
  assign irq = r_irq;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gpio_channel #(.DW(DW), .RST_OUT(RST_OUT)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_acc && req_write && w_ch == CH_W'(c)),
      .i_reg  (w_reg),
      .i_wdata(req_wdata[DW-1:0]),
      .i_pad  (gpio_in[c*DW +: DW]),
      .o_out  (gpio_out[c*DW +: DW]),
      .o_oe   (gpio_oe[c*DW +: DW]),
      .o_rdata(w_rd_ch[c]),
      .o_pend (w_pend[c])
    );
  end
  // select the addressed channel's readback
  always_comb begin
    w_rd = '0;
    for (int c = 0; c < NUM_CH; c++) w_rd = (w_ch == CH_W'(c)) ? w_rd_ch[c] : w_rd;
  end
  // one-outstanding host FSM with registered response and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
      r_err <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_pend;
      if (w_acc) begin
        r_state <= S_RESP;
        r_rdata <= (req_write || !w_ok) ? '0 : 32'(w_rd);
        r_err <= !w_ok;
      end else if (r_state == S_RESP && rsp_ready) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_vjtag_gpio_bank.sv
// tb_vjtag_gpio_bank: scoreboard-driven scenarios for the GPIO bank host interface
module tb_vjtag_gpio_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, irq;
  logic [31:0] rsp_rdata;
  logic [47:0] gpio_out, gpio_oe;
  logic [47:0] gpio_in = '0;
  logic [31:0] q_rd [$];
  bit          q_err [$];
  int          n_chk = 0, n_fail = 0;
  logic [47:0] o_at, e_at;

  vjtag_gpio_bank #(.NUM_CH(3), .DW(16), .RST_OUT(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .gpio_in(gpio_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic xact(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [31:0] er, input bit ee,
                      output logic [47:0] out_at, output logic [47:0] oe_at);
    logic [31:0] xr;
    bit xe;
    int n;
    q_rd.push_back(er);
    q_err.push_back(ee);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 8) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    out_at = gpio_out;
    oe_at = gpio_oe;
    xr = q_rd.pop_front();
    xe = q_err.pop_front();
    n_chk++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_latency addr=%h rsp_valid=%b required 1", addr, rsp_valid);
    end else begin
      n_chk++;
      if (rsp_rdata !== xr) begin
        n_fail++;
        $display("FAIL rdata addr=%h got %h required %h", addr, rsp_rdata, xr);
      end
      n_chk++;
      if (rsp_err !== xe) begin
        n_fail++;
        $display("FAIL err addr=%h got %b required %b", addr, rsp_err, xe);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_cycles(input int k);
    for (int i = 0; i < k; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    wait_cycles(3);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_err, irq} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl got rdy/vld/err/irq=%b required 1000", {req_ready, rsp_valid, rsp_err, irq});
    end
    n_chk++;
    if (gpio_out !== 48'h0 || gpio_oe !== 48'h0 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs got out=%h oe=%h rdata=%h required 0", gpio_out, gpio_oe, rsp_rdata);
    end
  endtask

  task automatic test_dir_out;
    xact(1'b1, 8'h01, 32'hFFFF_FFFF, 32'h0, 1'b0, o_at, e_at);
    n_chk++;
    if (e_at[15:0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL dir_oe got %h required FFFF", e_at[15:0]);
    end
    xact(1'b1, 8'h00, 32'h0000_00A5, 32'h0, 1'b0, o_at, e_at);
    n_chk++;
    if (o_at[15:0] !== 16'h00A5) begin
      n_fail++;
      $display("FAIL out_write got %h required 00A5", o_at[15:0]);
    end
  endtask

  task automatic test_set_clr;
    xact(1'b1, 8'h03, 32'h0000_0F00, 32'h0, 1'b0, o_at, e_at);
    xact(1'b1, 8'h04, 32'h0000_0005, 32'h0, 1'b0, o_at, e_at);
    xact(1'b0, 8'h00, 32'h0, 32'h0000_0FA0, 1'b0, o_at, e_at);
    xact(1'b0, 8'h03, 32'h0, 32'h0, 1'b0, o_at, e_at);
    xact(1'b0, 8'h01, 32'h0, 32'h0000_FFFF, 1'b0, o_at, e_at);
    n_chk++;
    if (gpio_out !== 48'h0000_0000_0FA0) begin
      n_fail++;
      $display("FAIL set_clr_out got %h required 000000000FA0", gpio_out);
    end
  endtask

  task automatic test_edge;
    int n;
    xact(1'b1, 8'h15, 32'h1, 32'h0, 1'b0, o_at, e_at);
    @(negedge clk); gpio_in[32] = 1'b1;
    n = 0;
    while (irq !== 1'b1 && n < 4) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_irq got %b required 1 within 4 cycles", irq);
    end
    xact(1'b0, 8'h12, 32'h0, 32'h0001, 1'b0, o_at, e_at);
    xact(1'b0, 8'h17, 32'h0, 32'h0001, 1'b0, o_at, e_at);
    xact(1'b1, 8'h17, 32'h1, 32'h0, 1'b0, o_at, e_at);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_irq got %b required 0", irq);
    end
    xact(1'b0, 8'h17, 32'h0, 32'h0, 1'b0, o_at, e_at);
  endtask

  task automatic test_w1c_collision;
    @(negedge clk); gpio_in[32] = 1'b0;
    wait_cycles(4);
    @(negedge clk); gpio_in[32] = 1'b1;
    wait_cycles(4);
    @(negedge clk); gpio_in[32] = 1'b0;
    wait_cycles(4);
    xact(1'b0, 8'h17, 32'h0, 32'h0001, 1'b0, o_at, e_at);
    @(negedge clk); gpio_in[32] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    xact(1'b1, 8'h17, 32'h1, 32'h0, 1'b0, o_at, e_at);
    xact(1'b0, 8'h17, 32'h0, 32'h0001, 1'b0, o_at, e_at);
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_irq got %b required 1", irq);
    end
  endtask

  task automatic test_bad_ch;
    xact(1'b0, 8'h28, 32'h0, 32'h0, 1'b1, o_at, e_at);
    xact(1'b1, 8'h28, 32'h1234, 32'h0, 1'b1, o_at, e_at);
    xact(1'b1, 8'h29, 32'hFFFF, 32'h0, 1'b1, o_at, e_at);
    n_chk++;
    if (gpio_out !== 48'h0000_0000_0FA0 || gpio_oe !== 48'h0000_0000_FFFF || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_ch_state got out=%h oe=%h irq=%b required 000000000FA0 00000000FFFF 1", gpio_out, gpio_oe, irq);
    end
    xact(1'b0, 8'h17, 32'h0, 32'h0001, 1'b0, o_at, e_at);
  endtask

  task automatic test_back_to_back;
    logic [31:0] xr;
    bit xe;
    q_rd.push_back(32'h0000_0FA0);
    q_err.push_back(1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00;
    @(posedge clk); #1;
    xr = q_rd.pop_front();
    xe = q_err.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== xr || rsp_err !== xe || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d got vld=%b rdata=%h err=%b rdy=%b required 1 %h %b 0", i, rsp_valid, rsp_rdata, rsp_err, req_ready, xr, xe);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_rsp got vld=%b rdata=%h err=%b irq=%b required 0 0 0 0", rsp_valid, rsp_rdata, rsp_err, irq);
    end
    n_chk++;
    if (gpio_out !== 48'h0 || gpio_oe !== 48'h0) begin
      n_fail++;
      $display("FAIL mid_rst_gpio got out=%h oe=%h required 0 0", gpio_out, gpio_oe);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_ready got %b required 1", req_ready);
    end
    xact(1'b0, 8'h17, 32'h0, 32'h0, 1'b0, o_at, e_at);
  endtask

  initial begin
    test_reset();
    test_dir_out();
    test_set_clr();
    test_edge();
    test_w1c_collision();
    test_bad_ch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vjtag_gpio_bank.md
VJTAG_GPIO_BANK -- requirements
Module: vjtag_gpio_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: GPIO channel count, legal 1..8.
REQ-002 SHALL have parameter DW, default 16: bits per channel, legal 1..32.
REQ-003 SHALL have parameter RST_OUT, default 0: reset value of every OUT bit.
REQ-004 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1: host request valid.
REQ-007 SHALL have port req_ready  out  1: request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_write  in  1: 1=write, 0=read.
REQ-009 SHALL have port req_addr  in  8: {channel[4:0], reg[2:0]}.
REQ-010 SHALL have port req_wdata  in  32: write data; bits above DW ignored.
REQ-011 SHALL have port rsp_valid  out  1: response valid.
REQ-012 SHALL have port rsp_ready  in  1: response consumed when rsp_valid && rsp_ready.
REQ-013 SHALL have port rsp_rdata  out  32: read data, zero-extended from DW.
REQ-014 SHALL have port rsp_err  out  1: channel index >= NUM_CH.
REQ-015 SHALL have port gpio_out  out  NUM_CH*DW: output values, channel c at [c*DW +: DW].
REQ-016 SHALL have port gpio_oe  out  NUM_CH*DW: per-bit output enable (1=drive).
REQ-017 SHALL have port gpio_in  in  NUM_CH*DW: asynchronous pad inputs.
REQ-018 SHALL have port irq  out  1: OR over all channels of (STATUS != 0), registered.

Function
REQ-019 SHALL implement per-channel registers: 0 OUT (RW), 1 DIR (RW, 1=output), 2 IN (RO), 3 SET (WO, OUT |= wdata), 4 CLR (WO, OUT &= ~wdata), 5 RISE_EN (RW), 6 FALL_EN (RW), 7 STATUS (R, write-1-to-clear).
REQ-020 SHALL drive gpio_out = OUT and gpio_oe = DIR directly from registers.
REQ-021 SHALL synchronise gpio_in through two flops; IN reads the second stage.
REQ-022 SHALL hold one previous-sample flop; rise = sync & ~prev & RISE_EN, fall = ~sync & prev & FALL_EN, each OR-ed into STATUS; STATUS sets 3 cycles after a pad change.
REQ-023 SHALL give set priority over W1C when a capture and a clear hit the same STATUS bit in the same cycle.
REQ-024 SHALL allow one outstanding transaction: req_ready = !rsp_valid.
REQ-025 SHALL register a response the cycle after acceptance (latency 1), holding rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
REQ-026 SHALL, with rsp_valid && rsp_ready in the same cycle, deassert rsp_valid next cycle; req_ready stays low in that cycle (no back-to-back acceptance).
REQ-027 SHALL return rsp_rdata 0 on writes and on reads of WO registers 3/4.
REQ-028 SHALL, for channel >= NUM_CH, ignore writes, return rdata 0 and rsp_err=1.
REQ-029 SHALL make register writes visible on outputs the cycle after acceptance.
REQ-030 SHALL leave RW registers unchanged by reads, including STATUS.

Reset
REQ-031 SHALL, under rst, set OUT=RST_OUT, DIR=0, RISE_EN=0, FALL_EN=0, STATUS=0, sync/prev flops=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, irq=0.
REQ-032 SHALL drop any pending response when rst asserts mid-transaction; req_ready=1 the cycle after rst releases.
REQ-033 SHALL suppress edge capture in the first cycle after reset release (prev is reloaded, not compared).

Structure
REQ-034 SHALL place register offsets (enum of 8 values), address field widths and MAX_CH in package vjtag_gpio_pkg.
REQ-035 SHALL instantiate one sub-module gpio_channel per channel (registers, sync, edge detect); the top holds the host FSM (IDLE/RESP) and the read mux.

Verification
REQ-036 SHALL test write DIR ch0=0xFFFF, OUT=0x00A5 -> gpio_oe[15:0]=0xFFFF, gpio_out[15:0]=0x00A5 one cycle after acceptance.
REQ-037 SHALL test SET 0x0F00 then CLR 0x0005 on ch0 -> OUT reads 0x0FA0.
REQ-038 SHALL test RISE_EN ch2=0x0001, toggle gpio_in bit 32 0->1 -> STATUS ch2=0x0001 and irq=1 within 4 cycles; W1C 0x0001 -> irq=0.
REQ-039 SHALL test W1C on STATUS in the same cycle as a new rising edge -> bit stays 1.
REQ-040 SHALL test read ch5 with NUM_CH=3 -> rsp_err=1, rdata=0, no state change.
REQ-041 SHALL test holding rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0; assert rst mid-wait -> rsp_valid=0 and all outputs at reset values.
